trace_cmd_scheduler: RTL and testbench

//  Sequences decoded trace commands (codes 0-9) into the L2 simulator in strict trace order.

---
 rtl/l2sim_pkg.sv | 70 +++++++
 rtl/cmd_fifo.sv | 55 +++++
 rtl/trace_cmd_scheduler.sv | 176 +++++++++++++++++
 tb/tb_trace_cmd_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l2sim_pkg.sv
// Shared types for the L2 simulator trace path: trace codes, request ops,
// scheduler states and the trace-code decoder.
package l2sim_pkg;

  typedef enum logic [3:0] {
    TC_DR      = 4'd0,
    TC_DW      = 4'd1,
    TC_IR      = 4'd2,
    TC_SN_INV  = 4'd3,
    TC_SN_RD   = 4'd4,
    TC_SN_WR   = 4'd5,
    TC_SN_RWIM = 4'd6,
    TC_CLEAR   = 4'd8,
    TC_PRINT   = 4'd9
  } trace_cmd_e;

  typedef enum logic [1:0] {
    L1_DR = 2'd0,
    L1_DW = 2'd1,
    L1_IR = 2'd2
  } l1_op_e;

  typedef enum logic [1:0] {
    SN_INV  = 2'd0,
    SN_RD   = 2'd1,
    SN_WR   = 2'd2,
    SN_RWIM = 2'd3
  } snoop_op_e;

  typedef enum logic [2:0] {
    K_L1,
    K_SNOOP,
    K_CLEAR,
    K_PRINT,
    K_ILLEGAL
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1,
    ST_SNOOP,
    ST_CLEAR,
    ST_PRINT
  } sched_state_e;

  typedef struct packed {
    cmd_kind_e  kind;
    logic [1:0] op;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_trace_cmd(input logic [3:0] code);
    cmd_dec_t d;
    d.kind = K_ILLEGAL;
    d.op   = 2'd0;
    case (code)
      TC_DR:      begin d.kind = K_L1;    d.op = L1_DR;   end
      TC_DW:      begin d.kind = K_L1;    d.op = L1_DW;   end
      TC_IR:      begin d.kind = K_L1;    d.op = L1_IR;   end
      TC_SN_INV:  begin d.kind = K_SNOOP; d.op = SN_INV;  end
      TC_SN_RD:   begin d.kind = K_SNOOP; d.op = SN_RD;   end
      TC_SN_WR:   begin d.kind = K_SNOOP; d.op = SN_WR;   end
      TC_SN_RWIM: begin d.kind = K_SNOOP; d.op = SN_RWIM; end
      TC_CLEAR:   d.kind = K_CLEAR;
      TC_PRINT:   d.kind = K_PRINT;
      default:    d.kind = K_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small command FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate counter.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: empty pointers mask stale entries.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/trace_cmd_scheduler.sv
// Issues buffered trace commands to L1, snoop, clear or print in trace order.
// Optional statistics counters: define TRACE_SCHED_STATS_EN.
module trace_cmd_scheduler
  import l2sim_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cmd,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              l1_valid,
  input  logic              l1_ready,
  output logic [1:0]        l1_op,
  output logic [ADDR_W-1:0] l1_addr,
  output logic              sn_valid,
  input  logic              sn_ready,
  output logic [1:0]        sn_op,
  output logic [ADDR_W-1:0] sn_addr,
  output logic              clr_req,
  input  logic              clr_ack,
  output logic              prt_req,
  input  logic              prt_ack,
  output logic              illegal,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_l1,
  output logic [CNT_W-1:0]  cnt_snoop,
  output logic [CNT_W-1:0]  cnt_maint,
  output logic [CNT_W-1:0]  cnt_illegal
);

  localparam int FW = 4 + ADDR_W;

  sched_state_e      state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              illegal_q, illegal_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_rdata;
  logic [3:0]        head_cmd;
  logic [ADDR_W-1:0] head_addr;
  cmd_dec_t          head_dec;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({in_cmd, in_addr}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_cmd  = fifo_rdata[FW-1:ADDR_W];
  assign head_addr = fifo_rdata[ADDR_W-1:0];
  assign head_dec  = decode_trace_cmd(head_cmd);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    illegal_d = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = head_dec.op;
          addr_d   = head_addr;
          case (head_dec.kind)
            K_L1:    state_d = ST_L1;
            K_SNOOP: state_d = ST_SNOOP;
            K_CLEAR: state_d = ST_CLEAR;
            K_PRINT: state_d = ST_PRINT;
            default: illegal_d = 1'b1;
          endcase
        end
      end
      ST_L1:    if (l1_ready) state_d = ST_IDLE;
      ST_SNOOP: if (sn_ready) state_d = ST_IDLE;
      ST_CLEAR: if (clr_ack)  state_d = ST_IDLE;
      ST_PRINT: if (prt_ack)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      illegal_q <= illegal_d;
    end
  end

  // Request lines come straight from the state flop so reset drops them at once.
  assign l1_valid = (state_q == ST_L1);
  assign sn_valid = (state_q == ST_SNOOP);
  assign clr_req  = (state_q == ST_CLEAR);
  assign prt_req  = (state_q == ST_PRINT);
  assign l1_op    = op_q;
  assign l1_addr  = addr_q;
  assign sn_op    = op_q;
  assign sn_addr  = addr_q;
  assign illegal  = illegal_q;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);

`ifdef TRACE_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_l1_q, cnt_l1_d;
  logic [CNT_W-1:0] cnt_sn_q, cnt_sn_d;
  logic [CNT_W-1:0] cnt_mt_q, cnt_mt_d;
  logic [CNT_W-1:0] cnt_il_q, cnt_il_d;
  logic             maint_done;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign maint_done = (clr_req && clr_ack) || (prt_req && prt_ack);

  always_comb begin
    cnt_l1_d = sat_inc(cnt_l1_q, l1_valid && l1_ready);
    cnt_sn_d = sat_inc(cnt_sn_q, sn_valid && sn_ready);
    cnt_mt_d = sat_inc(cnt_mt_q, maint_done);
    cnt_il_d = sat_inc(cnt_il_q, illegal_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_l1_q <= '0;
      cnt_sn_q <= '0;
      cnt_mt_q <= '0;
      cnt_il_q <= '0;
    end else begin
      cnt_l1_q <= cnt_l1_d;
      cnt_sn_q <= cnt_sn_d;
      cnt_mt_q <= cnt_mt_d;
      cnt_il_q <= cnt_il_d;
    end
  end

  assign cnt_l1      = cnt_l1_q;
  assign cnt_snoop   = cnt_sn_q;
  assign cnt_maint   = cnt_mt_q;
  assign cnt_illegal = cnt_il_q;
`else
  assign cnt_l1      = '0;
  assign cnt_snoop   = '0;
  assign cnt_maint   = '0;
  assign cnt_illegal = '0;
`endif

endmodule

// File: tb/tb_trace_cmd_scheduler.sv
// Directed bench for trace_cmd_scheduler; counter checks follow
// TRACE_SCHED_STATS_EN.
module tb_trace_cmd_scheduler;

`ifdef TRACE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = 4'd0;
  logic [31:0] in_addr = 32'd0;
  logic        l1_valid, l1_ready = 1'b0;
  logic [1:0]  l1_op;
  logic [31:0] l1_addr;
  logic        sn_valid, sn_ready = 1'b0;
  logic [1:0]  sn_op;
  logic [31:0] sn_addr;
  logic        clr_req, clr_ack = 1'b0;
  logic        prt_req, prt_ack = 1'b0;
  logic        illegal, busy;
  logic [31:0] cnt_l1, cnt_snoop, cnt_maint, cnt_illegal;

  int n_cmp = 0;
  int n_err = 0;

  trace_cmd_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cmd      (in_cmd),
    .in_addr     (in_addr),
    .l1_valid    (l1_valid),
    .l1_ready    (l1_ready),
    .l1_op       (l1_op),
    .l1_addr     (l1_addr),
    .sn_valid    (sn_valid),
    .sn_ready    (sn_ready),
    .sn_op       (sn_op),
    .sn_addr     (sn_addr),
    .clr_req     (clr_req),
    .clr_ack     (clr_ack),
    .prt_req     (prt_req),
    .prt_ack     (prt_ack),
    .illegal     (illegal),
    .busy        (busy),
    .cnt_l1      (cnt_l1),
    .cnt_snoop   (cnt_snoop),
    .cnt_maint   (cnt_maint),
    .cnt_illegal (cnt_illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic vld(input int kind);
    case (kind)
      0:       return l1_valid;
      1:       return sn_valid;
      2:       return clr_req;
      default: return prt_req;
    endcase
  endfunction

  task automatic set_rdy(input int kind, input logic v);
    case (kind)
      0:       l1_ready = v;
      1:       sn_ready = v;
      2:       clr_ack  = v;
      default: prt_ack  = v;
    endcase
  endtask

  // Called at a negedge; leaves inputs idle at the following negedge.
  task automatic push(input logic [3:0] cmd, input logic [31:0] addr);
    chk("push_rdy", in_ready, 1);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_addr  = addr;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Wait for a request, check it is held for `stall` cycles, then complete it.
  task automatic issue(input int kind, input logic [1:0] op,
                       input logic [31:0] addr, input int stall);
    int t = 0;
    while (!vld(kind) && t < 20) begin
      @(negedge clock);
      t++;
    end
    chk($sformatf("seen_k%0d", kind), vld(kind), 1);
    for (int i = 0; i <= stall; i++) begin
      chk("onehot", l1_valid + sn_valid + clr_req + prt_req, 1);
      if (kind == 0) begin
        chk("l1_op", l1_op, op);
        chk("l1_addr", l1_addr, addr);
      end else if (kind == 1) begin
        chk("sn_op", sn_op, op);
        chk("sn_addr", sn_addr, addr);
      end
      if (i < stall) @(negedge clock);
    end
    set_rdy(kind, 1'b1);
    @(negedge clock);
    set_rdy(kind, 1'b0);
    chk($sformatf("drop_k%0d", kind), vld(kind), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_reqs", {l1_valid, sn_valid, clr_req, prt_req}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // 1: single read, ready already high
    l1_ready = 1'b1;
    push(4'd0, 32'h1000);
    chk("t1_c2_valid", l1_valid, 0);
    chk("t1_busy", busy, 1);
    @(negedge clock);
    chk("t1_c3_valid", l1_valid, 1);
    chk("t1_op", l1_op, 0);
    chk("t1_addr", l1_addr, 32'h1000);
    @(negedge clock);
    chk("t1_width", l1_valid, 0);
    chk("t1_idle", busy, 0);
    l1_ready = 1'b0;

    // 2: ordering with stalls
    push(4'd1, 32'h2000);
    push(4'd3, 32'h3000);
    push(4'd2, 32'h4000);
    issue(0, 2'd1, 32'h2000, 5);
    issue(1, 2'd0, 32'h3000, 5);
    issue(0, 2'd2, 32'h4000, 5);

    // 3: fill the FIFO behind a pending clear
    push(4'd8, 32'h0);
    @(negedge clock);
    chk("t3_clr", clr_req, 1);
    push(4'd0, 32'h10);
    push(4'd1, 32'h14);
    push(4'd3, 32'h18);
    push(4'd6, 32'h1C);
    chk("t3_full", in_ready, 0);
    in_valid = 1'b1;
    in_cmd   = 4'd2;
    in_addr  = 32'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t3_blocked", in_ready, 0);
    end
    issue(2, 2'd0, 32'h0, 0);
    t = 0;
    while (!in_ready && t < 10) begin
      @(negedge clock);
      t++;
    end
    chk("t3_reopen", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    issue(0, 2'd0, 32'h10, 1);
    issue(0, 2'd1, 32'h14, 1);
    issue(1, 2'd0, 32'h18, 1);
    issue(1, 2'd3, 32'h1C, 1);
    issue(0, 2'd2, 32'h20, 1);
    @(negedge clock);
    chk("t3_drained", busy, 0);

    // 4: snoop waits behind a long clear
    push(4'd8, 32'h0);
    push(4'd5, 32'h5000);
    issue(2, 2'd0, 32'h0, 10);
    issue(1, 2'd2, 32'h5000, 0);
    chk("cnt_l1", cnt_l1, STATS ? 6 : 0);
    chk("cnt_snoop", cnt_snoop, STATS ? 4 : 0);
    chk("cnt_maint", cnt_maint, STATS ? 2 : 0);

    // 5: illegal codes are dropped with a pulse each
    @(negedge clock);
    push(4'd7, 32'h7000);
    chk("t5_pre", illegal, 0);
    @(negedge clock);
    chk("t5_pulse1", illegal, 1);
    @(negedge clock);
    chk("t5_end1", illegal, 0);
    push(4'hF, 32'hF000);
    @(negedge clock);
    chk("t5_pulse2", illegal, 1);
    chk("t5_noreq", {l1_valid, sn_valid, clr_req, prt_req}, 0);
    @(negedge clock);
    chk("t5_end2", illegal, 0);
    chk("t5_busy", busy, 0);
    chk("cnt_illegal", cnt_illegal, STATS ? 2 : 0);

    // 6: reset with a snoop outstanding and three entries queued
    push(4'd4, 32'h6000);
    push(4'd0, 32'h6100);
    push(4'd1, 32'h6200);
    push(4'd2, 32'h6300);
    chk("t6_sn", sn_valid, 1);
    chk("t6_rd", sn_op, 2'd1);
    reset = 1'b1;
    #1;
    chk("t6_sn_async", sn_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_in_ready", in_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    l1_ready = 1'b1;
    sn_ready = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clock);
    chk("t6_quiet", {l1_valid, sn_valid, clr_req, prt_req}, 0);
    chk("t6_busy_after", busy, 0);
    chk("t6_cnt_l1", cnt_l1, 0);
    chk("t6_cnt_il", cnt_illegal, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
